enc_cursor_ctrl: RTL and testbench

Parametrised two-axis cursor controller for the text display. Converts held or tapped encoder/button move codes into a character-cell cursor position (column, row, linear cell address), with auto-repeat while a move is held and a selectable saturate or wrap-with-line-carry edge mode. It replaces the single-axis, fixed-step pixel counter and feeds the character-buffer address and cursor-highlight logic directly.

---
 rtl/enc_cursor_ctrl_if.sv | 26 ++
 rtl/enc_cursor_ctrl.sv | 177 +++++++++++++++++
 tb/tb_enc_cursor_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/enc_cursor_ctrl_if.sv
// Cursor controller bus: move/home requests in, cursor position out.
interface enc_cursor_ctrl_if #(
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5,
    parameter int ADDR_W = 12
);
    logic [1:0]        move_x;
    logic [1:0]        move_y;
    logic              home;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic              moved;

    // Requester side (encoder/button front end)
    modport master (
        output move_x, move_y, home,
        input  col, row, addr, moved
    );

    // Controller side
    modport slave (
        input  move_x, move_y, home,
        output col, row, addr, moved
    );
endinterface

// File: rtl/enc_cursor_ctrl.sv
// Two-axis character-cell cursor controller with auto-repeat and
// selectable saturate / wrap-with-row-carry edge behaviour.
module enc_cursor_ctrl #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int WRAP         = 0,
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 2_500_000
) (
    input logic              clk,
    input logic              rst_n,
    enc_cursor_ctrl_if.slave bus
);
    localparam int COL_W   = (COLS > 2) ? $clog2(COLS) : 1;
    localparam int ROW_W   = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam int ADDR_W  = $clog2(COLS * ROWS);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [COL_W-1:0]         COL_MAX   = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]         COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0]         ROW_MAX   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]         ROW_ONE   = ROW_W'(1);
    localparam logic signed [ROW_W+1:0]  ROWS_S    = (ROW_W+2)'(ROWS);
    localparam logic [ADDR_W-1:0]        COLS_A    = ADDR_W'(COLS);
    localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]         DELAY_LIM = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]         RATE_LIM  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [3:0]        dir_q, dir_n;
    logic              step;

    logic [COL_W-1:0]  col_q, col_n;
    logic [ROW_W-1:0]  row_q, row_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              moved_q;

    // Code 11 is a no-move on its axis, so fold it to 00 before comparing
    // directions; a held 11 must not look different from a held 00.
    logic [1:0]        mx, my;
    logic [3:0]        dir;
    logic              dir_act;
    logic signed [1:0] dy, carry;
    logic signed [ROW_W+1:0] rsum;

    assign mx      = (bus.move_x == 2'b11) ? 2'b00 : bus.move_x;
    assign my      = (bus.move_y == 2'b11) ? 2'b00 : bus.move_y;
    assign dir     = {my, mx};
    assign dir_act = |dir;
    assign dy      = (my == 2'b10) ? 2'sb01 : (my == 2'b01) ? 2'sb11 : 2'sb00;

    // Repeat FSM state, timer and latched direction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            dir_q   <= dir_n;
        end
    end

    // Decide whether this edge takes a step and where the repeat timer goes
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dir_n   = dir_q;
        step    = 1'b0;
        if (bus.home) begin
            state_n = IDLE;
            cnt_n   = '0;
            dir_n   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dir_act) begin
                        step    = 1'b1;
                        dir_n   = dir;
                        cnt_n   = '0;
                        state_n = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (!dir_act) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (dir != dir_q) begin
                        // New direction restarts the full delay
                        step    = 1'b1;
                        dir_n   = dir;
                        cnt_n   = '0;
                        state_n = HOLD;
                    end else if (cnt_q == ((state_q == REPEAT) ? RATE_LIM : DELAY_LIM)) begin
                        step    = 1'b1;
                        cnt_n   = '0;
                        state_n = REPEAT;
                    end else begin
                        cnt_n   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Next cursor position: clamp per axis, or wrap column with row carry
    always_comb begin
        col_n = col_q;
        row_n = row_q;
        carry = 2'sb00;
        rsum  = '0;
        if (bus.home) begin
            col_n = '0;
            row_n = '0;
        end else if (step) begin
            if (WRAP == 0) begin
                if (mx == 2'b10 && col_q != COL_MAX)      col_n = col_q + COL_ONE;
                else if (mx == 2'b01 && col_q != '0)      col_n = col_q - COL_ONE;
                if (my == 2'b10 && row_q != ROW_MAX)      row_n = row_q + ROW_ONE;
                else if (my == 2'b01 && row_q != '0)      row_n = row_q - ROW_ONE;
            end else begin
                if (mx == 2'b10) begin
                    if (col_q == COL_MAX) begin
                        col_n = '0;
                        carry = 2'sb01;
                    end else begin
                        col_n = col_q + COL_ONE;
                    end
                end else if (mx == 2'b01) begin
                    if (col_q == '0) begin
                        col_n = COL_MAX;
                        carry = 2'sb11;
                    end else begin
                        col_n = col_q - COL_ONE;
                    end
                end
                // row + dy + carry spans -2..ROWS+1; one correction folds it back
                rsum = $signed({2'b00, row_q})
                     + $signed({{ROW_W{dy[1]}}, dy})
                     + $signed({{ROW_W{carry[1]}}, carry});
                if (rsum[ROW_W+1])        rsum = rsum + ROWS_S;
                else if (rsum >= ROWS_S)  rsum = rsum - ROWS_S;
                row_n = rsum[ROW_W-1:0];
            end
        end
        addr_n = ADDR_W'(row_n) * COLS_A + ADDR_W'(col_n);
    end

    // Cursor registers; addr is built from the next position so it never lags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            moved_q <= 1'b0;
        end else begin
            col_q   <= col_n;
            row_q   <= row_n;
            addr_q  <= addr_n;
            moved_q <= (col_n != col_q) || (row_n != row_q);
        end
    end

    assign bus.col   = col_q;
    assign bus.row   = row_q;
    assign bus.addr  = addr_q;
    assign bus.moved = moved_q;
endmodule

// File: tb/tb_enc_cursor_ctrl.sv
// Bench for enc_cursor_ctrl: a saturating and a wrapping instance share
// stimulus and are both checked against a behavioural model every cycle.
module tb_enc_cursor_ctrl;
    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int RD   = 4;
    localparam int RR   = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] mx, my;
    logic       hm;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 0;

    enc_cursor_ctrl_if #(.COL_W(2), .ROW_W(2), .ADDR_W(4)) b0 ();
    enc_cursor_ctrl_if #(.COL_W(2), .ROW_W(2), .ADDR_W(4)) b1 ();

    assign b0.move_x = mx;
    assign b0.move_y = my;
    assign b0.home   = hm;
    assign b1.move_x = mx;
    assign b1.move_y = my;
    assign b1.home   = hm;

    enc_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR))
        dut_sat (.clk(clk), .rst_n(rst_n), .bus(b0));
    enc_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR))
        dut_wrap (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // A step happens on the first cycle of a run of one active direction,
    // then at run ages RD, RD+RR, RD+2RR, ...
    int  mc[2], mr[2], mmv[2];
    int  run_age;
    bit  run_on;
    int  run_dir;
    int  m_dir, m_dx, m_dy;
    bit  m_step;

    function automatic int axis(input logic [1:0] code);
        return (code == 2'b10) ? 1 : (code == 2'b01) ? -1 : 0;
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    initial begin
        for (int w = 0; w < 2; w++) begin mc[w] = 0; mr[w] = 0; mmv[w] = 0; end
        run_age = 0; run_on = 0; run_dir = 0;
    end

    always @(posedge clk) begin
        m_dx  = axis(mx);
        m_dy  = axis(my);
        m_dir = (m_dy + 1) * 3 + (m_dx + 1);
        m_step = 0;
        if (!rst_n || hm || (m_dx == 0 && m_dy == 0)) begin
            run_on = 0;
        end else if (!run_on || m_dir != run_dir) begin
            run_on = 1; run_dir = m_dir; run_age = 0; m_step = 1;
        end else begin
            run_age++;
            m_step = (run_age == RD) || (run_age > RD && (run_age - RD) % RR == 0);
        end
        for (int w = 0; w < 2; w++) begin
            int nc, nr, idx;
            nc = mc[w]; nr = mr[w];
            if (!rst_n) begin
                nc = 0; nr = 0;
            end else if (hm) begin
                nc = 0; nr = 0;
            end else if (m_step) begin
                if (w == 0) begin
                    nc = clampi(nc + m_dx, COLS - 1);
                    nr = clampi(nr + m_dy, ROWS - 1);
                end else begin
                    // wrap mode is plain modular motion over the linear cell index
                    idx = nr * COLS + nc + m_dx + m_dy * COLS;
                    idx = ((idx % (COLS * ROWS)) + COLS * ROWS) % (COLS * ROWS);
                    nc  = idx % COLS;
                    nr  = idx / COLS;
                end
            end
            mmv[w] = rst_n && (nc != mc[w] || nr != mr[w]);
            mc[w]  = nc;
            mr[w]  = nr;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("sat.col",    32'(b0.col),   32'(mc[0]));
            cmp("sat.row",    32'(b0.row),   32'(mr[0]));
            cmp("sat.addr",   32'(b0.addr),  32'(mr[0] * COLS + mc[0]));
            cmp("sat.moved",  32'(b0.moved), 32'(mmv[0]));
            cmp("wrap.col",   32'(b1.col),   32'(mc[1]));
            cmp("wrap.row",   32'(b1.row),   32'(mr[1]));
            cmp("wrap.addr",  32'(b1.addr),  32'(mr[1] * COLS + mc[1]));
            cmp("wrap.moved", 32'(b1.moved), 32'(mmv[1]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_home();
        hm = 1; mx = 2'b00; my = 2'b00; tick(1);
        hm = 0;
    endtask

    int exp_col[9] = '{1, 1, 1, 1, 2, 2, 3, 3, 3};

    // ---------------- stimulus and literal expectations ----------------
    initial begin
        rst_n = 0; mx = 2'b10; my = 2'b00; hm = 0;
        @(posedge clk);
        chk_on = 1;
        // reset held with a move pending
        for (int i = 0; i < 3; i++) begin
            tick(1);
            cmp("rst.col",   32'(b0.col),   0);
            cmp("rst.addr",  32'(b0.addr),  0);
            cmp("rst.moved", 32'(b0.moved), 0);
        end
        rst_n = 1; tick(1);
        cmp("rel.col",   32'(b0.col),   1);
        cmp("rel.moved", 32'(b0.moved), 1);

        // tap and illegal code
        go_home();
        mx = 2'b10; tick(1);
        cmp("tap.col",   32'(b0.col),   1);
        cmp("tap.addr",  32'(b0.addr),  1);
        cmp("tap.moved", 32'(b0.moved), 1);
        mx = 2'b00; tick(5);
        cmp("tap.hold",  32'(b0.col),   1);
        mx = 2'b11; tick(10);
        cmp("ill.col",   32'(b0.col),   1);
        cmp("ill.moved", 32'(b0.moved), 0);

        // auto-repeat timing and saturation
        go_home();
        mx = 2'b10;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            cmp("rep.col", 32'(b0.col), 32'(exp_col[i]));
        end
        cmp("sat.edge8.moved", 32'(b0.moved), 0);
        mx = 2'b00; my = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            cmp("satup.row",   32'(b0.row),   0);
            cmp("satup.moved", 32'(b0.moved), 0);
        end

        // wrap with row carry
        go_home();
        mx = 2'b01; tick(1);
        cmp("wrapL.col",  32'(b1.col),  3);
        cmp("wrapL.row",  32'(b1.row),  2);
        cmp("wrapL.addr", 32'(b1.addr), 11);
        mx = 2'b00; tick(1);
        mx = 2'b10; tick(1);
        cmp("wrapR.addr", 32'(b1.addr), 0);
        mx = 2'b00; tick(1);
        go_home();
        for (int i = 0; i < 3; i++) begin
            mx = 2'b10; tick(1);
            mx = 2'b00; tick(1);
        end
        cmp("pre.col", 32'(b1.col), 3);
        mx = 2'b10; my = 2'b10; tick(1);
        cmp("diag.wcol",  32'(b1.col),  0);
        cmp("diag.wrow",  32'(b1.row),  2);
        cmp("diag.waddr", 32'(b1.addr), 8);
        cmp("diag.saddr", 32'(b0.addr), 7);
        mx = 2'b00; my = 2'b00; tick(1);

        // direction change restarts timing
        go_home();
        mx = 2'b10; tick(3);
        mx = 2'b00; my = 2'b10; tick(1);
        cmp("chg.row",   32'(b0.row),   1);
        cmp("chg.moved", 32'(b0.moved), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            cmp("chg.quiet", 32'(b0.moved), 0);
        end
        tick(1);
        cmp("chg.row2", 32'(b0.row), 2);
        my = 2'b00; tick(1);

        // home during repeat, then immediate re-step
        go_home();
        my = 2'b10; tick(1);
        my = 2'b00; tick(1);
        mx = 2'b10; tick(5);
        cmp("hrep.col", 32'(b0.col), 2);
        cmp("hrep.row", 32'(b0.row), 1);
        hm = 1; tick(1);
        cmp("home.addr",  32'(b0.addr),  0);
        cmp("home.moved", 32'(b0.moved), 1);
        hm = 0; tick(1);
        cmp("rehold.col",   32'(b0.col),   1);
        cmp("rehold.moved", 32'(b0.moved), 1);
        mx = 2'b00; tick(1);
        hm = 1; tick(1);
        hm = 0; tick(1);
        cmp("home00.moved", 32'(b0.moved), 0);

        // randomized segments
        for (int s = 0; s < 80; s++) begin
            mx = 2'($urandom_range(0, 3));
            my = 2'($urandom_range(0, 3));
            hm = ($urandom_range(0, 11) == 0);
            rst_n = ($urandom_range(0, 29) != 0);
            tick(1);
            hm = 0; rst_n = 1;
            tick($urandom_range(0, 9));
        end
        mx = 2'b00; my = 2'b00;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
